// File: rtl/rmst_to_fifo_tile.sv
// Tile loader: issues Avalon read-master bursts for a tile of 32-bit words and
// unpacks each 128-bit user beat into FIFO pushes, low word first, under a FIFO credit check.
module rmst_to_fifo_tile #(
  parameter int AW         = 12,
  parameter int CW         = 6,
  parameter int DW         = 32,
  parameter int XAW        = 32,
  parameter int XDW        = 128,
  parameter int BLEN       = 8,
  parameter int FIFO_DEPTH = 256,
  parameter int FCW        = 9
) (
  input  logic           clk,
  input  logic           rst,
  output logic           rmst_fixed_location,
  output logic [XAW-1:0] rmst_read_base,
  output logic [CW-1:0]  rmst_read_length,
  output logic           rmst_go,
  input  logic           rmst_done,
  output logic           rmst_user_read_buffer,
  input  logic [XDW-1:0] rmst_user_buffer_data,
  input  logic           rmst_user_data_available,
  input  logic           config_done,
  input  logic [AW-1:0]  param_iolen,
  input  logic [XAW-1:0] param_raddr,
  input  logic           load_data_start,
  output logic           load_data_done,
  output logic           fifo_push,
  output logic [DW-1:0]  fifo_data_in,
  input  logic           fifo_full,
  input  logic [FCW-1:0] fifo_count
);

  localparam int WCNT = XDW / DW;
  localparam int UW   = $clog2(WCNT + 1);
  localparam int SW   = AW + 2;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  iolen, rd_len, issued, pushed, chunk;
  logic [XAW-1:0] base, addr;
  logic [XDW-1:0] ureg;
  logic [UW-1:0]  ucnt;
  logic [SW-1:0]  credit;
  logic           done_q, start_load, go_req, done_rise, active;

  assign rmst_fixed_location = 1'b0;
  assign rmst_read_base      = addr;
  assign chunk               = (rd_len < AW'(BLEN)) ? rd_len : AW'(BLEN);
  assign rmst_read_length    = CW'({chunk, 2'b00});

  // Words already requested but not yet pushed still occupy future FIFO space.
  assign credit    = SW'(fifo_count) + SW'(issued - pushed) + SW'(chunk);
  assign go_req    = (state == S_ISSUE) && !rmst_go && rmst_done && (credit <= SW'(FIFO_DEPTH));
  assign done_rise = !done_q && rmst_done;
  assign active    = (state == S_ISSUE) || (state == S_WAIT) || (state == S_DRAIN);
  assign start_load = load_data_start && ((state == S_IDLE) || (state == S_DONE));

  assign fifo_push    = (ucnt != '0) && !fifo_full;
  assign fifo_data_in = ureg[DW-1:0];
  // Refill on the same cycle the last held word leaves, so pushes stay back to back.
  assign rmst_user_read_buffer = active && rmst_user_data_available &&
                                 ((ucnt == '0) || ((ucnt == UW'(1)) && fifo_push));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start_load)                           state_nxt = (iolen == '0) ? S_DONE : S_ISSUE;
        else if (state == S_DONE && config_done)  state_nxt = S_IDLE;
      end
      S_ISSUE: if (rmst_go)   state_nxt = S_WAIT;
      S_WAIT:  if (done_rise) state_nxt = (rd_len != '0) ? S_ISSUE : S_DRAIN;
      S_DRAIN: if ((pushed == iolen) && (ucnt == '0)) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register sees pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q         <= 1'b0;
      rmst_go        <= 1'b0;
      load_data_done <= 1'b0;
      iolen          <= '0;
      base           <= '0;
      rd_len         <= '0;
      addr           <= '0;
      issued         <= '0;
      pushed         <= '0;
      // NOTE: the unpack register is reset as well, so fifo_data_in reads 0 out of reset.
      ureg           <= '0;
      ucnt           <= '0;
    end else begin
      done_q         <= rmst_done;
      rmst_go        <= go_req;
      load_data_done <= (state_nxt == S_DONE);

      if (config_done) begin
        iolen <= param_iolen;
        base  <= param_raddr;
      end

      if (start_load) begin
        rd_len <= iolen;
        addr   <= base;
        issued <= '0;
      end else if (rmst_go) begin
        addr   <= addr + XAW'({chunk, 2'b00});
        rd_len <= rd_len - chunk;
        issued <= issued + chunk;
      end

      if (start_load)     pushed <= '0;
      else if (fifo_push) pushed <= pushed + AW'(1);

      if (rmst_user_read_buffer) begin
        ureg <= rmst_user_buffer_data;
        ucnt <= UW'(WCNT);
      end else if (fifo_push) begin
        ureg <= ureg >> DW;
        ucnt <= ucnt - UW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rmst_to_fifo_tile.sv
// Directed bench for rmst_to_fifo_tile: behavioural read master whose memory word
// at byte address a holds a>>2, with a push scoreboard and command log.
module tb_rmst_to_fifo_tile;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rmst_fixed_location;
  logic [31:0]  rmst_read_base;
  logic [5:0]   rmst_read_length;
  logic         rmst_go;
  logic         rmst_done = 1'b1;
  logic         rmst_user_read_buffer;
  logic [127:0] rmst_user_buffer_data = '0;
  logic         rmst_user_data_available = 1'b0;
  logic         config_done = 1'b0;
  logic [11:0]  param_iolen = '0;
  logic [31:0]  param_raddr = '0;
  logic         load_data_start = 1'b0;
  logic         load_data_done;
  logic         fifo_push;
  logic [31:0]  fifo_data_in;
  logic         fifo_full = 1'b0;
  logic [8:0]   fifo_count = '0;

  always #5 clk = ~clk;

  rmst_to_fifo_tile dut (
    .clk                      (clk),
    .rst                      (rst),
    .rmst_fixed_location      (rmst_fixed_location),
    .rmst_read_base           (rmst_read_base),
    .rmst_read_length         (rmst_read_length),
    .rmst_go                  (rmst_go),
    .rmst_done                (rmst_done),
    .rmst_user_read_buffer    (rmst_user_read_buffer),
    .rmst_user_buffer_data    (rmst_user_buffer_data),
    .rmst_user_data_available (rmst_user_data_available),
    .config_done              (config_done),
    .param_iolen              (param_iolen),
    .param_raddr              (param_raddr),
    .load_data_start          (load_data_start),
    .load_data_done           (load_data_done),
    .fifo_push                (fifo_push),
    .fifo_data_in             (fifo_data_in),
    .fifo_full                (fifo_full),
    .fifo_count               (fifo_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- read-master model and scoreboard ----------------
  logic [127:0] mq[$];
  logic [31:0]  go_base[$];
  logic [5:0]   go_len[$];
  logic [31:0]  got_words[$];
  int           pend = 0;
  int           tb_ucnt = 0;
  logic [31:0]  maddr = '0;
  logic         ack_seen = 1'b0;
  logic         push_seen = 1'b0;

  function automatic logic [127:0] beat(input logic [31:0] a);
    return {(a + 32'd12) >> 2, (a + 32'd8) >> 2, (a + 32'd4) >> 2, a >> 2};
  endfunction

  // Outputs change on the falling edge; ack/push are sampled 1 time unit later and
  // take effect at the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      pend = 0;
      tb_ucnt = 0;
      rmst_done = 1'b1;
      ack_seen = 1'b0;
      push_seen = 1'b0;
      rmst_user_data_available = 1'b0;
      rmst_user_buffer_data = '0;
    end else begin
      if (ack_seen) void'(mq.pop_front());
      if (push_seen) tb_ucnt--;
      if (ack_seen) tb_ucnt = 4;
      if (rmst_go) begin
        go_base.push_back(rmst_read_base);
        go_len.push_back(rmst_read_length);
        maddr = rmst_read_base;
        pend = int'(rmst_read_length) / 16;
        rmst_done = 1'b0;
      end else if (pend > 0) begin
        mq.push_back(beat(maddr));
        maddr += 32'd16;
        pend--;
      end else if (!rmst_done) begin
        rmst_done = 1'b1;
      end
      rmst_user_data_available = (mq.size() != 0);
      rmst_user_buffer_data = (mq.size() != 0) ? mq[0] : '0;
      #1;
      ack_seen = rmst_user_read_buffer;
      push_seen = fifo_push;
      if (push_seen) got_words.push_back(fifo_data_in);
      if (ack_seen) check("ack_rule", 64'((tb_ucnt == 0) || (tb_ucnt == 1 && push_seen)), 64'd1);
    end
  end

  logic tog_en = 1'b0;
  int   tog_cnt = 0;
  always @(negedge clk) begin
    if (tog_en) begin
      tog_cnt++;
      if (tog_cnt == 3) begin
        tog_cnt = 0;
        fifo_full = ~fifo_full;
      end
    end else begin
      tog_cnt = 0;
      fifo_full = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_logs();
    go_base.delete();
    go_len.delete();
    got_words.delete();
  endtask

  task automatic configure(input logic [11:0] len, input logic [31:0] addr);
    @(negedge clk);
    param_iolen = len;
    param_raddr = addr;
    config_done = 1'b1;
    @(negedge clk);
    config_done = 1'b0;
  endtask

  task automatic start();
    @(negedge clk);
    load_data_start = 1'b1;
    @(negedge clk);
    load_data_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !load_data_done; i++) @(negedge clk);
    check({tag, "_done"}, 64'(load_data_done), 64'd1);
  endtask

  task automatic check_go(input string tag, input int idx, input logic [31:0] b, input logic [5:0] l);
    check({tag, "_go_base"}, 64'((idx < go_base.size()) ? go_base[idx] : 32'hFFFF_FFFF), 64'(b));
    check({tag, "_go_len"},  64'((idx < go_len.size())  ? go_len[idx]  : 6'h3F), 64'(l));
  endtask

  task automatic check_words(input string tag, input int n, input logic [31:0] first);
    check({tag, "_push_count"}, 64'(got_words.size()), 64'(n));
    for (int k = 0; k < n; k++)
      check({tag, "_word"}, 64'((k < got_words.size()) ? got_words[k] : 32'hDEAD_BEEF),
            64'(first + 32'(k)));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("rst_go",     64'(rmst_go), 64'd0);
    check("rst_fixed",  64'(rmst_fixed_location), 64'd0);
    check("rst_base",   64'(rmst_read_base), 64'd0);
    check("rst_len",    64'(rmst_read_length), 64'd0);
    check("rst_ack",    64'(rmst_user_read_buffer), 64'd0);
    check("rst_done",   64'(load_data_done), 64'd0);
    check("rst_push",   64'(fifo_push), 64'd0);
    check("rst_fdata",  64'(fifo_data_in), 64'd0);
    rst = 1'b0;

    // Two full bursts.
    configure(12'd16, 32'h1000);
    clear_logs();
    start();
    wait_done("t16", 300);
    check("t16_pushes_at_done", 64'(got_words.size()), 64'd16);
    check("t16_go_count", 64'(go_base.size()), 64'd2);
    check_go("t16_0", 0, 32'h1000, 6'd32);
    check_go("t16_1", 1, 32'h1020, 6'd32);
    check_words("t16", 16, 32'h400);

    // Short final burst.
    configure(12'd12, 32'h1000);
    check("cfg_clears_done", 64'(load_data_done), 64'd0);
    clear_logs();
    start();
    wait_done("t12", 300);
    repeat (5) @(negedge clk);
    check("t12_go_count", 64'(go_base.size()), 64'd2);
    check_go("t12_0", 0, 32'h1000, 6'd32);
    check_go("t12_1", 1, 32'h1020, 6'd16);
    check_words("t12", 12, 32'h400);

    // Back-pressure from the FIFO every 3 cycles.
    configure(12'd16, 32'h1000);
    clear_logs();
    tog_en = 1'b1;
    start();
    wait_done("tfull", 600);
    tog_en = 1'b0;
    check_words("tfull", 16, 32'h400);

    // Credit limit: 250 + 8 > 256, 249 + 8 > 256, 248 + 8 == 256.
    fifo_count = 9'd250;
    configure(12'd8, 32'h1000);
    clear_logs();
    start();
    repeat (20) @(negedge clk);
    check("credit_250_no_go", 64'(go_base.size()), 64'd0);
    fifo_count = 9'd249;
    repeat (10) @(negedge clk);
    check("credit_249_no_go", 64'(go_base.size()), 64'd0);
    fifo_count = 9'd248;
    wait_done("tcred", 300);
    fifo_count = 9'd0;
    check("credit_go_count", 64'(go_base.size()), 64'd1);
    check_go("tcred", 0, 32'h1000, 6'd32);
    check_words("tcred", 8, 32'h400);

    // Zero-length tile.
    configure(12'd0, 32'h1000);
    clear_logs();
    @(negedge clk);
    load_data_start = 1'b1;
    @(negedge clk);
    load_data_start = 1'b0;
    check("zero_done_next_cycle", 64'(load_data_done), 64'd1);
    repeat (10) @(negedge clk);
    check("zero_go_count", 64'(go_base.size()), 64'd0);
    check("zero_push_count", 64'(got_words.size()), 64'd0);

    // Reset right after the first go, then reload.
    configure(12'd16, 32'h2000);
    clear_logs();
    start();
    for (int i = 0; i < 50 && !rmst_go; i++) @(negedge clk);
    check("mid_go_seen", 64'(rmst_go), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_go",   64'(rmst_go), 64'd0);
    check("mid_rst_base", 64'(rmst_read_base), 64'd0);
    check("mid_rst_len",  64'(rmst_read_length), 64'd0);
    check("mid_rst_ack",  64'(rmst_user_read_buffer), 64'd0);
    check("mid_rst_push", 64'(fifo_push), 64'd0);
    check("mid_rst_done", 64'(load_data_done), 64'd0);
    check("mid_rst_fdata", 64'(fifo_data_in), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    configure(12'd8, 32'h3000);
    clear_logs();
    start();
    wait_done("trel", 300);
    check("trel_go_count", 64'(go_base.size()), 64'd1);
    check_go("trel", 0, 32'h3000, 6'd32);
    check_words("trel", 8, 32'hC00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rmst_to_fifo_tile.md
Name: rmst_to_fifo_tile

Overview:
Read-side counterpart of the store path. The block loads a tile of `param_iolen` 32-bit words from external memory into an on-chip FIFO. It does this by issuing burst commands to the Avalon read master and acknowledging its 128-bit user buffer. It then unpacks each 128-bit beat into 32-bit FIFO pushes, least-significant word first. A credit check guarantees the FIFO can never be overrun by data already requested.

Parameters:
AW, 12, width of word-count parameters and counters
CW, 6, width of the read-master byte length field
DW, 32, FIFO word width
XAW, 32, external byte-address width
XDW, 128, read-master user data width
WCNT, XDW/DW, words per beat (4)
BLEN, 8, max words per burst command; multiple of WCNT; BLEN*4 < 2^CW
FIFO_DEPTH, 256, capacity of the downstream FIFO in words
FCW, 9, width of fifo_count (holds 0..FIFO_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset
rmst_fixed_location  out  1  constant 0
rmst_read_base  out  XAW  byte address of current command
rmst_read_length  out  CW  byte length of current command
rmst_go  out  1  one-cycle command strobe
rmst_done  in  1  high while master idle
rmst_user_read_buffer  out  1  acknowledge/pop of user data
rmst_user_buffer_data  in  XDW  show-ahead user data
rmst_user_data_available  in  1  user data valid
config_done  in  1  latch parameters
param_iolen  in  AW  tile length in words; multiple of WCNT
param_raddr  in  XAW  tile start byte address
load_data_start  in  1  start pulse
load_data_done  out  1  tile fully pushed
fifo_push  out  1  FIFO write enable
fifo_data_in  out  DW  FIFO write data
fifo_full  in  1  FIFO full
fifo_count  in  FCW  current FIFO occupancy

Behaviour:
Reset and clock:
- Reset rst, asynchronous, active-high; clock clk.
- Reset state: all outputs 0, all counters 0, FSM in IDLE.

Parameter latch:
- `config_done` latches `param_iolen` into `iolen` and `param_raddr` into `base`.
- `config_done` also clears `load_data_done`.

FSM states IDLE, ISSUE, WAIT, DRAIN, DONE:
- IDLE: on `load_data_start`, load `rd_len`=`iolen`, `addr`=`base`, clear `issued`/`pushed`.
  - If `iolen`==0, go to DONE; otherwise go to ISSUE. `load_data_start` is ignored outside IDLE and DONE.
- ISSUE: `chunk`=min(`rd_len`, BLEN).
  - `rmst_read_base`=`addr`; `rmst_read_length`=`chunk`*4 (combinational, valid whenever `rmst_go` is high).
  - `rmst_go` is a registered one-cycle pulse, raised when `rmst_done`==1 and `fifo_count`+(`issued`-`pushed`)+`chunk` <= FIFO_DEPTH.
  - On the go edge: `addr`+=`chunk`*4, `rd_len`-=`chunk`, `issued`+=`chunk`; move to WAIT.
- WAIT: on a `rmst_done` rising edge (registered `done`=0, current=1), return to ISSUE if `rd_len`!=0, else go to DRAIN.
  - A rising edge that coincides with the go cycle is ignored.
- DRAIN: when `pushed`==`iolen` and the unpack register is empty, go to DONE.
- DONE: `load_data_done`=1 (level). Held until `load_data_start` (re-enters IDLE path) or `config_done`.

Unpack path (active in ISSUE/WAIT/DRAIN):
- State: 128-bit `ureg` plus a word counter `ucnt` (0..WCNT).
- `fifo_push` = (`ucnt`!=0) && !`fifo_full`; `fifo_data_in` = `ureg`[DW-1:0].
- On each push: `ureg` shifts right by DW, `ucnt`-=1, `pushed`+=1.
- `rmst_user_read_buffer` (combinational) = `rmst_user_data_available` && ((`ucnt`==0) || (`ucnt`==1 && `fifo_push`)).
- On acknowledge: `ureg` <= `rmst_user_buffer_data`, `ucnt` <= WCNT. This sustains one word per cycle.

Latency and boundary conditions:
- Latency: a beat acknowledged at cycle t yields pushes at t+1..t+WCNT when the FIFO is not full.
- `fifo_full`: pushes stall and hold word order; data is never dropped.
- Credit never lets requested-but-unpushed words exceed FIFO free space.
- Counters are AW bits wide; `iolen` <= 2^AW-1 requires no wrap handling.
- Reset mid-burst: everything clears immediately. The master is expected to be reset by the same rst.

Test Plan:
- `iolen`=16, `raddr`=0x1000, master ideal -> two gos: (0x1000, 32), (0x1020, 32); 16 pushes of words 0..15 in address order; `load_data_done` high after the 16th push.
- `iolen`=12 -> gos (0x1000, 32), (0x1020, 16); exactly 12 pushes; done.
- `fifo_full` toggled every 3 cycles during unpack -> no duplicate or lost words; `rmst_user_read_buffer` only when `ucnt`==0 or 1 with push.
- `fifo_count`=250, `iolen`=8 -> no go until `fifo_count` <= 248; then a single go with length 32.
- `iolen`=0 with start -> no go, no push; `load_data_done`=1 one cycle after start.
- rst asserted after the first go -> all outputs 0 immediately; a new config and start reload from `param_raddr`.
